// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               q_bit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    trial    = rem_sh - {1'b0, opnd};
    q_bit    = 1'b0;
    acc_next = acc;
    if (is_div) begin
      // No borrow means the divisor fits; the quotient bit goes in via q_bit.
      q_bit    = ~trial[WIDTH];
      acc_next = {(q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
    end else if (acc[0]) begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end else begin
      acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned MULT/DIV unit with Hi/Lo results and start/done handshake.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  state_e               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 neg_q, neg_d;
  logic                 rem_neg_q, rem_neg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 dz_q, dz_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 sgn;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [2*WIDTH-1:0]   prod;
  logic [2*WIDTH-1:0]   step_acc;
  logic                 step_q;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic is_signed);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    return (is_signed && sv < 0) ? -sv : sv;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_q),
    .opnd     (opnd_q),
    .is_div   (op_is_div(op_q)),
    .acc_next (step_acc),
    .q_bit    (step_q)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    cnt_d     = cnt_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    sgn       = op_is_signed(op);
    a_mag     = mag(a, sgn);
    b_mag     = mag(b, sgn);
    prod      = cond_neg2(acc_q, neg_q);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d      = op;
          neg_d     = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
          rem_neg_d = sgn & a[WIDTH-1];
          dz_d      = 1'b0;
          cnt_d     = CNT_W'(WIDTH - 1);
          state_d   = ST_RUN;
          if (op_is_div(op)) begin
            acc_d  = {{WIDTH{1'b0}}, a_mag};
            opnd_d = b_mag;
            if (b == '0) begin
              dz_d    = 1'b1;
              state_d = ST_DONE;
            end
          end else begin
            acc_d  = {{WIDTH{1'b0}}, b_mag};
            opnd_d = a_mag;
          end
        end
      end
      ST_RUN: begin
        acc_d = step_acc | {{(2*WIDTH-1){1'b0}}, step_q};
        if (cnt_q == '0) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_FIX: begin
        // Quotient follows the operand-sign XOR, remainder follows the dividend.
        if (op_is_div(op_q)) begin
          lo_d = cond_neg(acc_q[WIDTH-1:0], neg_q);
          hi_d = cond_neg(acc_q[2*WIDTH-1:WIDTH], rem_neg_q);
        end else begin
          lo_d = prod[WIDTH-1:0];
          hi_d = prod[2*WIDTH-1:WIDTH];
        end
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= 2'b00;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit replacing the separate fixed 32-bit multiplier and divider in the multicycle CPU. It runs signed or unsigned MULT/DIV through one shared shift-based datapath, using a start/done handshake with the control unit. It produces Hi/Lo results in MIPS convention and a divide-by-zero flag for the exception path. Hi/Lo outputs feed the Hi/Lo registers directly.

Parameters:
WIDTH, 32, operand width in bits; hi/lo are each WIDTH bits; must be ≥4 and even.
CNT_W, $clog2(WIDTH), width of the iteration counter (derived; do not override).

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high; clears all state on the next rising edge
start  in  1  request pulse; sampled only in IDLE
op  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; sampled with start
a  in  WIDTH  multiplicand / dividend (A register); sampled with start
b  in  WIDTH  multiplier / divisor (B register); sampled with start
busy  out  1  high from the cycle after start is accepted until the DONE cycle inclusive
done  out  1  one-cycle pulse; hi/lo/div_zero are valid in this cycle
hi  out  WIDTH  MULT: upper product half; DIV: remainder
lo  out  WIDTH  MULT: lower product half; DIV: quotient
div_zero  out  1  set with done when a DIV/DIVU had b==0; held until the next accepted start

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0. Reset overrides start and aborts any operation in flight; partial results are discarded.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE, start=1:
  - capture op and the operand magnitudes: for signed ops take the two's-complement absolute value; for unsigned ops take the raw value;
  - record result signs: product/quotient negative = a[MSB]^b[MSB]; remainder negative = a[MSB]; signed ops only;
  - clear div_zero; counter=WIDTH-1.
  - DIV/DIVU with b==0: go straight to DONE with div_zero=1; hi/lo keep their previous values.
  - Otherwise go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, one iteration per cycle, exactly WIDTH cycles; move to FIX when counter==0, otherwise decrement.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring division, one quotient bit per cycle, MSB first.
- FIX (1 cycle): conditionally negate the product (2*WIDTH-bit negate), quotient and remainder per the recorded signs; load hi/lo.
- DONE (1 cycle): done=1, busy=1, then go to IDLE.
- Latency from the cycle start is sampled to the done cycle:
  - normal operation: WIDTH+2 cycles (34 for WIDTH=32);
  - divide by zero: 1 cycle.
- start while not in IDLE is ignored and not queued. start in the DONE cycle is also ignored.
- Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Overflow case DIV of the most-negative value by -1: lo=most-negative value, hi=0. No flag is raised.
- MULT/MULTU never overflow (full 2*WIDTH result).
- Outputs are registered. hi/lo change only in FIX, or on reset.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - FSM state encodings: ST_IDLE, ST_RUN, ST_FIX, ST_DONE.
- One natural sub-module, muldiv_step: combinational single iteration. Inputs are accumulator, operand magnitude and mode; outputs are the next accumulator and the quotient bit. It is instantiated once in muldiv_unit, which keeps the FSM, counter and sign fix-up.

Test Plan:
1. MULT a=FFFFFFFD (-3), b=00000007 → done exactly 34 cycles after start; hi=FFFFFFFF, lo=FFFFFFEB; div_zero=0; busy high for cycles 1..34.
2. MULTU a=FFFFFFFF, b=FFFFFFFF → hi=FFFFFFFE, lo=00000001. MULT on the same operands → hi=00000000, lo=00000001.
3. DIV a=FFFFFFF9 (-7), b=2 → lo=FFFFFFFD, hi=FFFFFFFF. DIVU a=7, b=2 → lo=3, hi=1. DIV a=80000000, b=FFFFFFFF → lo=80000000, hi=0.
4. Preload hi/lo via MULT 3*5 (hi=0, lo=F), then DIV a=5, b=0 → done 1 cycle after start; div_zero=1; hi=0, lo=F unchanged. The next MULT start clears div_zero.
5. start pulse with different operands at cycle 10 of a running MULT, and again in its DONE cycle → both ignored; results match the original operands; no second done.
6. Assert reset at cycle 15 of a DIVU → next edge gives busy=0, done=0, hi=0, lo=0, state IDLE. A new start the cycle after reset deasserts runs normally.
